fetch_stage: RTL

Instruction-fetch stage of the five-stage RISC-V pipeline. It holds the program counter and drives `PCF` to the combinational instruction memory. It takes the returned instruction word and registers it into the IF/ID pipeline register for the decode stage. It also applies hazard-unit stall and flush requests and execute-stage redirects (branch/jump).

---
 rtl/fetch_stage_pkg.sv | 20 ++
 rtl/fetch_pipe_reg.sv | 23 ++
 rtl/fetch_stage.sv | 94 +++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared pipeline constants and the IF/ID bundle type
package fetch_stage_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR_ENC    = 32'h00000013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h00000000;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
    } ifid_t;

    // Fetch addresses are always word aligned.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return addr & ~(XLEN'(3));
    endfunction

endpackage

// File: rtl/fetch_pipe_reg.sv
// rtl/fetch_pipe_reg.sv - register with sync reset, sync clear, enable and a clear value
module fetch_pipe_reg #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Clear has priority over enable so a flush overrides a stall.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            q <= CLR_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RISC-V instruction fetch stage with PC and IF/ID register; optional FETCH_PERF_CNT_EN counters
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_ENC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] FetchCnt,
    output logic [31:0] StallCnt,
    output logic [31:0] FlushCnt
`endif
);

    localparam ifid_t IFID_BUBBLE = '{instr: NOP_INSTR, pc: '0, pc_plus4: '0, valid: 1'b0};

    logic [31:0] pc_plus4_f;
    logic [31:0] pc_next;
    logic        pc_en;
    ifid_t       ifid_d;
    ifid_t       ifid_q;

    assign pc_plus4_f = PCF + 32'd4;
    // A redirect must land even while the hazard unit stalls fetch.
    assign pc_next    = PCSrcE ? align_pc(PCTargetE) : pc_plus4_f;
    assign pc_en      = PCSrcE || !StallF;

    fetch_pipe_reg #(
        .WIDTH   (32),
        .CLR_VAL (RESET_PC)
    ) u_pc_reg (
        .clk   (clk),
        .reset (reset),
        .clear (1'b0),
        .en    (pc_en),
        .d     (pc_next),
        .q     (PCF)
    );

    assign ifid_d = '{instr: InstrF, pc: PCF, pc_plus4: pc_plus4_f, valid: 1'b1};

    fetch_pipe_reg #(
        .WIDTH   ($bits(ifid_t)),
        .CLR_VAL (IFID_BUBBLE)
    ) u_ifid_reg (
        .clk   (clk),
        .reset (reset),
        .clear (FlushD),
        .en    (!StallD),
        .d     (ifid_d),
        .q     (ifid_q)
    );

    assign InstrD   = ifid_q.instr;
    assign PCD      = ifid_q.pc;
    assign PCPlus4D = ifid_q.pc_plus4;
    assign ValidD   = ifid_q.valid;

`ifdef FETCH_PERF_CNT_EN
    logic fetch_evt;
    logic stall_evt;

    assign fetch_evt = !FlushD && !StallD;
    assign stall_evt = StallF && !PCSrcE;

    // Saturating counters: they stick at all-ones rather than wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            FetchCnt <= '0;
            StallCnt <= '0;
            FlushCnt <= '0;
        end else begin
            if (fetch_evt && (FetchCnt != '1)) FetchCnt <= FetchCnt + 32'd1;
            if (stall_evt && (StallCnt != '1)) StallCnt <= StallCnt + 32'd1;
            if (FlushD    && (FlushCnt != '1)) FlushCnt <= FlushCnt + 32'd1;
        end
    end
`endif

endmodule
